// File: rtl/seq_scan_ctrl.sv
// ============================================================================
// seq_scan_ctrl : streams a word MSB-first into an external 1101 Mealy
//                 detector and returns the hit count and first-hit position.
// Revision 1.0
// ============================================================================
`default_nettype none

module seq_scan_ctrl #(
  parameter int WIDTH = 8,
  parameter int CNT_W = 4,
  localparam int IDX_W = $clog2(WIDTH)
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_data,
  output logic             det_x,
  output logic             det_rst,
  input  logic             det_y,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [CNT_W-1:0] out_count,
  output logic             out_hit,
  output logic [IDX_W-1:0] out_first_pos
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    CLEAR = 2'd1,
    SHIFT = 2'd2,
    DONE  = 2'd3
  } state_t;

  localparam logic [CNT_W-1:0] C_CNT_MAX  = '1;
  localparam logic [CNT_W-1:0] C_CNT_ONE  = CNT_W'(1);
  localparam logic [IDX_W-1:0] C_IDX_ONE  = IDX_W'(1);
  localparam logic [IDX_W-1:0] C_IDX_LAST = IDX_W'(WIDTH - 1);

  state_t           r_state;
  logic [WIDTH-1:0] r_shreg;
  logic [IDX_W-1:0] r_idx;
  logic [CNT_W-1:0] r_count;
  logic             r_hit;
  logic [IDX_W-1:0] r_first_pos;
  logic             r_det_x;
  logic             r_det_rst;
  logic             r_out_valid;
  logic             r_in_ready;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state     <= IDLE;
      r_shreg     <= '0;
      r_idx       <= '0;
      r_count     <= '0;
      r_hit       <= 1'b0;
      r_first_pos <= '0;
      r_det_x     <= 1'b0;
      r_det_rst   <= 1'b1;
      r_out_valid <= 1'b0;
      r_in_ready  <= 1'b1;
    end else begin
      case (r_state)
        IDLE: begin
          if (in_valid) begin
            r_shreg     <= in_data;
            r_count     <= '0;
            r_hit       <= 1'b0;
            r_first_pos <= '0;
            r_in_ready  <= 1'b0;
            r_state     <= CLEAR;
          end
        end
        CLEAR: begin
          // Detector leaves reset here, one edge before it consumes bit 0.
          r_idx     <= '0;
          r_det_rst <= 1'b0;
          r_det_x   <= r_shreg[WIDTH-1];
          r_state   <= SHIFT;
        end
        SHIFT: begin
          if (det_y) begin
            if (r_count != C_CNT_MAX) r_count <= r_count + C_CNT_ONE;
            if (!r_hit) begin
              r_hit       <= 1'b1;
              r_first_pos <= r_idx;
            end
          end
          r_shreg <= {r_shreg[WIDTH-2:0], 1'b0};
          r_idx   <= r_idx + C_IDX_ONE;
          if (r_idx == C_IDX_LAST) begin
            r_det_x     <= 1'b0;
            r_out_valid <= 1'b1;
            r_state     <= DONE;
          end else begin
            // det_x is registered, so preload the bit that follows.
            r_det_x <= r_shreg[WIDTH-2];
          end
        end
        DONE: begin
          if (out_ready) begin
            r_out_valid <= 1'b0;
            r_det_rst   <= 1'b1;
            r_in_ready  <= 1'b1;
            r_state     <= IDLE;
          end
        end
        default: r_state <= IDLE;
      endcase
    end
  end

  assign in_ready      = r_in_ready;
  assign det_x         = r_det_x;
  assign det_rst       = r_det_rst;
  assign out_valid     = r_out_valid;
  assign out_count     = r_count;
  assign out_hit       = r_hit;
  assign out_first_pos = r_first_pos;

endmodule

`default_nettype wire
